// File: rtl/linebuf_pingpong_sched.sv
// Write-side sequencer and bank arbiter for a two-bank ping-pong line buffer.
// Accepts a valid/ready pixel stream and drives the buffer write port
// (we / wr_addr / wr_data / eol / line_idx / wr_bank) one cycle after each
// accepted pixel. Tracks each bank's fill state, tells the reader when a bank
// holds NUM_LINES complete lines, and back-pressures the stream when the next
// bank to fill is still owned by the reader.
module linebuf_pingpong_sched #(
  parameter int NUM_LINES  = 3,    // lines per bank (kernel height), 1..15
  parameter int LINE_WIDTH = 224,  // pixels per line, 2..16384
  parameter int DATA_WIDTH = 16    // pixel width in bits
) (
  input  logic                  clk,
  input  logic                  reset,
  // pixel stream
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  // buffer write port
  output logic                  we,
  output logic [13:0]           wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  eol,
  output logic                  wr_bank,
  output logic [3:0]            line_idx,
  // reader handshake
  output logic                  rd_valid,
  output logic                  rd_bank,
  input  logic                  rd_release,
  output logic                  release_err
);

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  localparam logic [13:0] LAST_COL  = 14'(LINE_WIDTH - 1);
  localparam logic [3:0]  LAST_LINE = 4'(NUM_LINES - 1);

  // Per-bank fill state and the write-side fill pointer.
  bank_state_e state_q [2];
  bank_state_e state_d [2];
  logic        fill_bank_q, fill_bank_d;
  logic [13:0] col_q, col_d;
  logic [3:0]  line_q, line_d;

  // Reader ownership and error flag.
  logic        rd_bank_q, rd_bank_d;
  logic        release_err_q, release_err_d;

  // Registered buffer write port.
  logic                  we_q, we_d;
  logic [13:0]           wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  eol_q, eol_d;
  logic                  wr_bank_q, wr_bank_d;
  logic [3:0]            line_idx_q, line_idx_d;

  logic accept;
  logic last_col;
  logic last_line;
  logic release_ok;

  // Flow control and reader status are pure decodes of the bank state, so a
  // release raises in_ready only after the state register has updated.
  always_comb begin
    in_ready   = (state_q[fill_bank_q] != BANK_FULL);
    rd_valid   = (state_q[rd_bank_q] == BANK_FULL);
    accept     = in_valid & in_ready;
    release_ok = rd_release & rd_valid;
    last_col   = (col_q == LAST_COL);
    last_line  = (line_q == LAST_LINE);
  end

  // Next-state: write counters, bank fill states, reader ownership and the
  // one-cycle-delayed write port.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d       = state_q;
    fill_bank_d   = fill_bank_q;
    col_d         = col_q;
    line_d        = line_q;
    rd_bank_d     = rd_bank_q;
    release_err_d = release_err_q | (rd_release & ~rd_valid);

    we_d       = accept;
    eol_d      = accept & last_col;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    line_idx_d = line_idx_q;
    wr_bank_d  = wr_bank_q;

    if (accept) begin
      // The write port captures the pre-advance position and target bank.
      wr_addr_d  = col_q;
      wr_data_d  = in_data;
      line_idx_d = line_q;
      wr_bank_d  = fill_bank_q;

      if (state_q[fill_bank_q] == BANK_EMPTY) begin
        state_d[fill_bank_q] = BANK_FILLING;
      end

      if (last_col) begin
        col_d = '0;
        if (last_line) begin
          line_d               = '0;
          state_d[fill_bank_q] = BANK_FULL;
          fill_bank_d          = ~fill_bank_q;
        end else begin
          line_d = line_q + 4'd1;
        end
      end else begin
        col_d = col_q + 14'd1;
      end
    end

    // A valid release only ever targets a FULL bank, and a write only ever
    // targets a non-FULL bank, so the two updates never touch the same entry.
    if (release_ok) begin
      state_d[rd_bank_q] = BANK_EMPTY;
      rd_bank_d          = ~rd_bank_q;
    end
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q[0]    <= BANK_EMPTY;
      state_q[1]    <= BANK_EMPTY;
      fill_bank_q   <= 1'b0;
      col_q         <= '0;
      line_q        <= '0;
      rd_bank_q     <= 1'b0;
      release_err_q <= 1'b0;
      we_q          <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      eol_q         <= 1'b0;
      wr_bank_q     <= 1'b0;
      line_idx_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q[0]    <= state_d[0];
      state_q[1]    <= state_d[1];
      fill_bank_q   <= fill_bank_d;
      col_q         <= col_d;
      line_q        <= line_d;
      rd_bank_q     <= rd_bank_d;
      release_err_q <= release_err_d;
      we_q          <= we_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      eol_q         <= eol_d;
      wr_bank_q     <= wr_bank_d;
      line_idx_q    <= line_idx_d;
    end
  end

  assign we          = we_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign eol         = eol_q;
  assign wr_bank     = wr_bank_q;
  assign line_idx    = line_idx_q;
  assign rd_bank     = rd_bank_q;
  assign release_err = release_err_q;

endmodule

// File: tb/tb_linebuf_pingpong_sched.sv
// Scoreboard bench for linebuf_pingpong_sched with a 4-pixel x 3-line bank.
// Stimulus pushes the expected buffer write for every accepted pixel; an
// independent monitor pops and compares whenever we is high.
module tb_linebuf_pingpong_sched;

  localparam int NUM_LINES  = 3;
  localparam int LINE_WIDTH = 4;
  localparam int DATA_WIDTH = 16;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data = '0;
  logic                  we;
  logic [13:0]           wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  eol;
  logic                  wr_bank;
  logic                  rd_valid;
  logic                  rd_bank;
  logic                  rd_release = 1'b0;
  logic [3:0]            line_idx;
  logic                  release_err;

  typedef struct packed {
    logic [13:0]           addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  eol;
    logic [3:0]            line;
    logic                  bank;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  linebuf_pingpong_sched #(
    .NUM_LINES (NUM_LINES),
    .LINE_WIDTH(LINE_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .we         (we),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .eol        (eol),
    .wr_bank    (wr_bank),
    .rd_valid   (rd_valid),
    .rd_bank    (rd_bank),
    .rd_release (rd_release),
    .line_idx   (line_idx),
    .release_err(release_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && we) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_we actual=1 required=0 wr_addr=%0d at %0t", wr_addr, $time);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr",  32'(wr_addr),  32'(e.addr));
          check("wr_data",  32'(wr_data),  32'(e.data));
          check("eol",      32'(eol),      32'(e.eol));
          check("line_idx", 32'(line_idx), 32'(e.line));
          check("wr_bank",  32'(wr_bank),  32'(e.bank));
        end
      end
    end
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset      = 1'b1;
    in_valid   = 1'b0;
    rd_release = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Sends n pixels; pixel i is frame position first_idx+i within the bank.
  // Expected write: addr = k%4, line = k/4, eol on addr 3, given bank.
  task automatic send_burst(input int n, input int first_idx,
                            input logic [DATA_WIDTH-1:0] data_base,
                            input logic bank, input bit gap);
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      int   k = first_idx + i;
      int   waited = 0;
      exp_t e;
      in_valid = 1'b1;
      in_data  = data_base + DATA_WIDTH'(i);
      @(negedge clk);
      while (!in_ready && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      if (!in_ready) begin
        checks++;
        failures++;
        $display("FAIL in_ready_timeout actual=0 required=1 pixel=%0d", k);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      e.addr = 14'(k % LINE_WIDTH);
      e.data = data_base + DATA_WIDTH'(i);
      e.eol  = ((k % LINE_WIDTH) == LINE_WIDTH - 1);
      e.line = 4'(k / LINE_WIDTH);
      e.bank = bank;
      exp_q.push_back(e);
      #1;
      if (gap) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_we",          32'(we),          32'd0);
    check("rst_wr_addr",     32'(wr_addr),     32'd0);
    check("rst_eol",         32'(eol),         32'd0);
    check("rst_line_idx",    32'(line_idx),    32'd0);
    check("rst_wr_bank",     32'(wr_bank),     32'd0);
    check("rst_rd_bank",     32'(rd_bank),     32'd0);
    check("rst_rd_valid",    32'(rd_valid),    32'd0);
    check("rst_release_err", 32'(release_err), 32'd0);
    check("rst_in_ready",    32'(in_ready),    32'd1);

    // 12 back-to-back pixels fill bank 0
    send_burst(12, 0, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    check("b0_full_rd_valid", 32'(rd_valid), 32'd1);
    check("b0_full_rd_bank",  32'(rd_bank),  32'd0);
    check("b0_full_in_ready", 32'(in_ready), 32'd1);

    // 12 more fill bank 1; no release so the writer stalls
    send_burst(12, 0, 16'h000D, 1'b1, 1'b0);
    @(negedge clk);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_rd_valid", 32'(rd_valid), 32'd1);
    check("stall_rd_bank",  32'(rd_bank),  32'd0);
    in_valid = 1'b1;
    in_data  = 16'h0099;
    repeat (3) begin
      @(negedge clk);
      check("stall_we", 32'(we), 32'd0);
    end

    // Release bank 0 while stalled; in_ready rises only next cycle
    @(posedge clk);
    #1;
    rd_release = 1'b1;
    @(negedge clk);
    check("rel_in_ready_same_cycle", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rd_release = 1'b0;
    in_valid   = 1'b0;
    @(negedge clk);
    check("rel_rd_bank",     32'(rd_bank),     32'd1);
    check("rel_rd_valid",    32'(rd_valid),    32'd1);
    check("rel_in_ready",    32'(in_ready),    32'd1);
    check("rel_release_err", 32'(release_err), 32'd0);
    send_burst(1, 0, 16'h0019, 1'b0, 1'b0);

    // Release with no data sets a sticky error
    do_reset();
    @(posedge clk);
    #1;
    rd_release = 1'b1;
    @(posedge clk);
    #1;
    rd_release = 1'b0;
    @(negedge clk);
    check("bad_rel_rd_valid",    32'(rd_valid),    32'd0);
    check("bad_rel_release_err", 32'(release_err), 32'd1);
    check("bad_rel_rd_bank",     32'(rd_bank),     32'd0);
    repeat (3) @(negedge clk);
    check("bad_rel_sticky", 32'(release_err), 32'd1);
    do_reset();
    @(negedge clk);
    check("bad_rel_cleared", 32'(release_err), 32'd0);

    // Gapped stream: same address/eol pattern, we only after accepts
    send_burst(12, 0, 16'h0001, 1'b0, 1'b1);
    @(negedge clk);
    check("gap_rd_valid", 32'(rd_valid), 32'd1);
    check("gap_rd_bank",  32'(rd_bank),  32'd0);

    // Reset mid-frame, then a full bank from scratch
    do_reset();
    send_burst(5, 0, 16'h0100, 1'b0, 1'b0);
    do_reset();
    @(negedge clk);
    check("midrst_we",       32'(we),       32'd0);
    check("midrst_rd_valid", 32'(rd_valid), 32'd0);
    send_burst(11, 0, 16'h0200, 1'b0, 1'b0);
    @(negedge clk);
    check("midrst_rd_valid_11", 32'(rd_valid), 32'd0);
    send_burst(1, 11, 16'h020B, 1'b0, 1'b0);
    @(negedge clk);
    check("midrst_rd_valid_12", 32'(rd_valid), 32'd1);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
